// File: rtl/spi_slave_rx.sv
// SPI byte receiver (sck idles high, sampled on rising edge) with a receive buffer.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register.
module spi_slave_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs,
    input  logic              dc,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_dc,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    logic sck_s1, sck_s2, sck_s3;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic dc_s1, dc_s2;
    logic sck_rise;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] byte_p0;
    logic              byte_dc_p0;
    logic              vld_p0;

    logic push, pop, full, accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1  <= 1'b1;
            sck_s2  <= 1'b1;
            sck_s3  <= 1'b1;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            dc_s1   <= 1'b0;
            dc_s2   <= 1'b0;
        end else begin
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_s3  <= sck_s2;
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            dc_s1   <= dc;
            dc_s2   <= dc_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_s3;

    // Stage p0: completed byte captured together with dc, pushed into the buffer next clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_p0    <= '0;
            byte_dc_p0 <= 1'b0;
            vld_p0     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            vld_p0    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!cs_s2) state <= SHIFT;
                end
                SHIFT: begin
                    if (cs_s2) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else if (sck_rise) begin
                        shreg   <= {shreg[DATA_W-2:0], mosi_s2};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_W-1)) begin
                            byte_p0    <= {shreg[DATA_W-2:0], mosi_s2};
                            byte_dc_p0 <= dc_s2;
                            vld_p0     <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign push   = vld_p0;
    assign pop    = rx_valid & rx_ready;
    // A pop on the same clk frees the slot, so a push into a full buffer still lands.
    assign accept = push & (~full | pop);

`ifdef SPI_SLAVE_RX_FIFO_EN
    logic [DATA_W:0] mem [4];
    logic [1:0]      wr_ptr, rd_ptr;
    logic [2:0]      count;

    assign full = (count == 3'd4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {byte_dc_p0, byte_p0};
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            case ({accept, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign rx_valid          = (count != 3'd0);
    assign {rx_dc, rx_data}  = mem[rd_ptr];
`else
    logic [DATA_W:0] hold;
    logic            hold_vld;

    assign full = hold_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
        end else begin
            if (accept) begin
                hold     <= {byte_dc_p0, byte_p0};
                hold_vld <= 1'b1;
            end else if (pop) begin
                hold_vld <= 1'b0;
            end
        end
    end

    assign rx_valid         = hold_vld;
    assign {rx_dc, rx_data} = hold;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) overrun <= 1'b0;
        else      overrun <= push & full & ~pop;
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized self-checking bench for spi_slave_rx; a queue model predicts the accepted bytes.
`timescale 1ns/1ps
module tb_spi_slave_rx;
`ifdef SPI_SLAVE_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0, rst = 1'b0, sck = 1'b1, mosi = 1'b0, cs = 1'b1, dc = 1'b0, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic rx_dc, rx_valid, overrun, frame_err;

    spi_slave_rx dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .cs(cs), .dc(dc),
        .rx_data(rx_data), .rx_dc(rx_dc), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int cyc = 0;
    int h = 6;
    int last_byte_rise = -1000;
    int lat = 99;
    bit meas_en = 1'b0;
    int mode = 0;
    int low_run = 0;
    int ovr_cnt = 0, ferr_cnt = 0, vld_rises = 0, stab_err = 0;
    logic [8:0] obs[$];
    logic [8:0] exp_q[$];
    logic prev_v = 1'b0, prev_r = 1'b0;
    logic [8:0] prev_d = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer and monitor: samples on the falling clk edge, sets rx_ready for the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_v && !prev_r && (!rx_valid || {rx_dc, rx_data} != prev_d)) stab_err++;
                if (rx_valid && !prev_v) begin
                    vld_rises++;
                    if (meas_en) begin
                        lat = cyc - last_byte_rise - 1;
                        meas_en = 1'b0;
                    end
                end
                case (mode)
                    0: rx_ready = 1'b1;
                    1: rx_ready = 1'b0;
                    2: begin
                        rx_ready = (low_run >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                        low_run  = rx_ready ? 0 : low_run + 1;
                    end
                    default: rx_ready = (cyc == last_byte_rise + lat);
                endcase
                if (rx_valid && rx_ready) obs.push_back({rx_dc, rx_data});
                if (overrun) ovr_cnt++;
                if (frame_err) ferr_cnt++;
                prev_v = rx_valid;
                prev_r = rx_ready;
                prev_d = {rx_dc, rx_data};
            end else begin
                prev_v = 1'b0;
                prev_r = 1'b0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic frame_start();
        step(1);
        cs = 1'b0;
    endtask

    task automatic frame_end();
        step(h);
        cs = 1'b1;
        step(8);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dcv);
        for (int i = 0; i < n; i++) begin
            step(h);
            sck  = 1'b0;
            mosi = b[3'(7 - i)];
            dc   = (i == 7) ? dcv : 1'($urandom_range(0, 1));
            step(h);
            sck  = 1'b1;
            if (i == 7) last_byte_rise = cyc;
        end
    endtask

    task automatic clr();
        obs.delete();
        exp_q.delete();
        ovr_cnt = 0;
        ferr_cnt = 0;
        vld_rises = 0;
    endtask

    task automatic cmp_queue(input string tag);
        check({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) check(tag, obs[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic dcv;
        logic [7:0] b;
        int nb, part, exp_ferr;

        step(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_dc", rx_dc, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b1;
        step(4);

        // Single byte at 1 us half period, also measures push latency with an empty buffer
        h = 100; clr(); mode = 0; meas_en = 1'b1;
        frame_start(); send_bits(8'hA5, 8, 1'b1); frame_end(); step(10);
        exp_q.push_back({1'b1, 8'hA5});
        check("a5_valid_pulses", vld_rises, 1);
        cmp_queue("a5");
        check("a5_frame_err", ferr_cnt, 0);
        check("latency_le4", (lat >= 0 && lat <= 4), 1);

        // Back-to-back bytes under one cs low
        h = $urandom_range(4, 8); clr(); mode = 0;
        frame_start();
        dcv = 1'($urandom_range(0, 1)); send_bits(8'h3C, 8, dcv); exp_q.push_back({dcv, 8'h3C});
        dcv = 1'($urandom_range(0, 1)); send_bits(8'hC3, 8, dcv); exp_q.push_back({dcv, 8'hC3});
        frame_end(); step(10);
        cmp_queue("b2b");
        check("b2b_overrun", ovr_cnt, 0);

        // Overflow with the consumer stalled: first DEPTH bytes kept, rest dropped
        h = $urandom_range(4, 8); clr(); mode = 1;
        frame_start();
        for (int i = 1; i <= 5; i++) begin
            dcv = 1'($urandom_range(0, 1));
            send_bits(8'(i), 8, dcv);
            if (i <= DEPTH) exp_q.push_back({dcv, 8'(i)});
        end
        frame_end(); step(10);
        check("ovr_pulses", ovr_cnt, 5 - DEPTH);
        check("ovr_held_valid", rx_valid, 1);
        check("ovr_head", {rx_dc, rx_data}, exp_q[0]);
        mode = 0; step(20);
        cmp_queue("ovr_drain");

        // Pop and push on the same clk while full: no overrun, order kept
        h = $urandom_range(4, 8); clr(); mode = 1;
        frame_start();
        for (int i = 1; i <= DEPTH + 1; i++) begin
            dcv = 1'($urandom_range(0, 1));
            if (i == DEPTH + 1) begin
                last_byte_rise = -1000;
                mode = 3;
            end
            send_bits(8'(8'h10 + i), 8, dcv);
            exp_q.push_back({dcv, 8'(8'h10 + i)});
        end
        frame_end(); step(5);
        check("simul_overrun", ovr_cnt, 0);
        check("simul_pops", obs.size(), 1);
        check("simul_still_full", rx_valid, 1);
        mode = 0; step(20);
        cmp_queue("simul_drain");

        // Partial frame then a good byte
        h = $urandom_range(4, 8); clr(); mode = 0;
        frame_start(); send_bits(8'hFF, 5, 1'b0); frame_end(); step(5);
        check("ferr_pulses", ferr_cnt, 1);
        check("ferr_no_valid", vld_rises, 0);
        dcv = 1'($urandom_range(0, 1));
        frame_start(); send_bits(8'h81, 8, dcv); frame_end(); step(10);
        exp_q.push_back({dcv, 8'h81});
        cmp_queue("after_ferr");
        check("after_ferr_pulses", ferr_cnt, 1);

        // Reset mid-byte with a byte already buffered
        h = $urandom_range(4, 8); clr(); mode = 1;
        frame_start(); send_bits(8'h77, 8, 1'b1); frame_end(); step(10);
        check("pre_rst_valid", rx_valid, 1);
        frame_start(); send_bits(8'hC0, 4, 1'b0);
        #2 rst = 1'b0;
        step(2);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_data", rx_data, 0);
        check("mid_rst_dc", rx_dc, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_frame_err", frame_err, 0);
        cs = 1'b1; sck = 1'b1;
        step(2); rst = 1'b1; step(4);
        clr(); mode = 0;
        dcv = 1'($urandom_range(0, 1));
        frame_start(); send_bits(8'h5A, 8, dcv); frame_end(); step(10);
        exp_q.push_back({dcv, 8'h5A});
        cmp_queue("post_rst");
        check("post_rst_frame_err", ferr_cnt, 0);
        check("post_rst_overrun", ovr_cnt, 0);

        // Random frames with a random but never-starving consumer
        clr(); mode = 2; exp_ferr = 0;
        for (int f = 0; f < 12; f++) begin
            h = $urandom_range(4, 8);
            nb = $urandom_range(0, 3);
            part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
            frame_start();
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                dcv = 1'($urandom_range(0, 1));
                send_bits(b, 8, dcv);
                exp_q.push_back({dcv, b});
            end
            if (part != 0) begin
                send_bits(8'($urandom), part, 1'b0);
                exp_ferr++;
            end
            frame_end();
        end
        step(20); mode = 0; step(20);
        cmp_queue("rand");
        check("rand_frame_err", ferr_cnt, exp_ferr);
        check("rand_overrun", ovr_cnt, 0);
        check("hold_stable", stab_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous assert, active-low.
REQ-003 SHALL have port sck, input, 1, SPI clock from the master; idles high; asynchronous to clk.
REQ-004 SHALL have port mosi, input, 1, serial data, MSB first; master changes it on sck falling edge.
REQ-005 SHALL have port cs, input, 1, chip select, active-low.
REQ-006 SHALL have port dc, input, 1, data/command flag; sampled with the byte's bit 0.
REQ-007 SHALL have port rx_data, output, 8, received byte at the head of the buffer.
REQ-008 SHALL have port rx_dc, output, 1, dc flag paired with rx_data.
REQ-009 SHALL have port rx_valid, output, 1, buffer non-empty; rx_data and rx_dc are valid.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts head entry when rx_valid and rx_ready are both high on a clk edge.
REQ-011 SHALL have port overrun, output, 1, one-clk pulse: a completed byte was dropped because the buffer was full.
REQ-012 SHALL have port frame_err, output, 1, one-clk pulse: cs deasserted with 1-7 bits shifted.

Function
REQ-013 SHALL pass sck, mosi, cs and dc through 2-flop synchronizers; sck edges are detected from synchronizer stage 2 versus a stage-3 history flop.
REQ-014 SHALL require sck high and low phases of at least 4 clk periods each; slower sck is unrestricted.
REQ-015 SHALL implement states IDLE (cs high) and SHIFT (cs low); IDLE->SHIFT on synchronized cs low; SHIFT->IDLE on synchronized cs high.
REQ-016 SHALL, in SHIFT, on each detected sck rising edge shift synchronized mosi into bit 0 of an 8-bit shift register and increment a 3-bit bit counter.
REQ-017 SHALL, on the rising edge that completes bit 7 (counter wraps 7->0), capture the shifted byte and synchronized dc and write them to the buffer on the next clk.
REQ-018 SHALL stay in SHIFT after a byte completes, so back-to-back bytes under one cs low are received without a gap.
REQ-019 SHALL ignore sck falling edges and any sck activity while in IDLE.
REQ-020 SHALL assert rx_valid no later than 4 clk edges after the clk edge where sck_sync stage 1 first samples the 8th rising edge.
REQ-021 SHALL, when cs rises with counter nonzero, discard the partial byte, clear the counter, and pulse frame_err for one clk.
REQ-022 SHALL, when the buffer is full and a byte completes, drop the new byte, keep the buffer contents unchanged, and pulse overrun for one clk.
REQ-023 SHALL treat a pop and a push on the same clk while full as accepted (no overrun), and buffer occupancy stays unchanged.
REQ-024 SHALL hold rx_data and rx_dc stable while rx_valid is high and rx_ready is low.

Reset
REQ-025 SHALL, while rst is low, force: state IDLE, counter 0, shift register 0x00, buffer empty, rx_valid 0, rx_data 0x00, rx_dc 0, overrun 0, frame_err 0, and synchronizers to idle values (sck 1, cs 1, mosi 0, dc 0).
REQ-026 SHALL, when reset asserts mid-byte, lose the partial byte and all buffered bytes; after release, reception starts only after a fresh cs falling edge is synchronized.

Configuration
REQ-027 SHALL use macro SPI_SLAVE_RX_FIFO_EN: when defined, the buffer is a 4-entry FIFO with 2-bit pointers that wrap 3->0 and a 3-bit count, with full at count 4; when undefined, the buffer is a single holding register with full equal to rx_valid; the ports are identical in both builds.

Verification
REQ-028 SHALL cover this case: with clk 100 MHz and sck half-period 1 us, cs low, send 0xA5 with dc=1, then raise cs -> exactly one rx_valid with rx_data=0xA5 and rx_dc=1; frame_err stays 0.
REQ-029 SHALL cover this case: send 0x3C then 0xC3 under one cs low with rx_ready held high -> two accepted entries, in order 0x3C then 0xC3.
REQ-030 SHALL cover this case: hold rx_ready low and send 5 bytes 0x01..0x05 -> with FIFO_EN, 0x01..0x04 are kept and one overrun pulse occurs on byte 5; without FIFO_EN, 0x01 is kept and four overrun pulses occur.
REQ-031 SHALL cover this case: raise cs after 5 bits of 0xFF -> one frame_err pulse and no rx_valid; the next full byte 0x81 is received as 0x81.
REQ-032 SHALL cover this case: assert rst after 4 bits, release it, then send 0x5A -> all outputs take reset values during reset, and the received byte is 0x5A.
REQ-033 SHALL cover this case: with FIFO_EN, full FIFO and rx_ready high on the same clk that a byte completes -> no overrun, count stays 4, and order is preserved.
